// File: rtl/can_form_checker_p_if.sv
// can_form_checker_p_if: bundle of the sample strobe, sampled bit, field code
// and form-checker results shared by the checker and the logic that drives it.
//   Sample_Strobe  one-cycle pulse at the bit sample point
//   Bit_Entrada    sampled bus bit (0 = dominant)
//   Estado         field code from the bit FSM
//   Form_monitor   sticky flags [0] SRR, [1] CRC delim, [2] ACK delim, [3] EOF
//   Form_error     one-cycle pulse on the first form error of a frame
//   Eof_err_pos    EOF bit index of the first EOF error
//   Frame_done     one-cycle pulse after the last EOF bit
//   Err_count      saturating count of erroneous frames
// master: the side producing strobe/bit/field code; slave: the checker.
interface can_form_checker_p_if #(
  parameter int unsigned ESTADO_W = 6,
  parameter int unsigned CNT_W    = 8
);
  logic                Sample_Strobe;
  logic                Bit_Entrada;
  logic [ESTADO_W-1:0] Estado;
  logic [3:0]          Form_monitor;
  logic                Form_error;
  logic [3:0]          Eof_err_pos;
  logic                Frame_done;
  logic [CNT_W-1:0]    Err_count;

  modport master (
    output Sample_Strobe, Bit_Entrada, Estado,
    input  Form_monitor, Form_error, Eof_err_pos, Frame_done, Err_count
  );

  modport slave (
    input  Sample_Strobe, Bit_Entrada, Estado,
    output Form_monitor, Form_error, Eof_err_pos, Frame_done, Err_count
  );
endinterface

// File: rtl/can_form_checker_p.sv
// can_form_checker_p: CAN receive-path form-error monitor. On each sample
// strobe it checks the fixed-form fields (SRR, CRC delimiter, ACK delimiter,
// EOF) named by the field code and keeps per-frame sticky flags, a pulse on
// the first error, the position of the first EOF error and a frame-done pulse.
// Ports:
//   Clock_TB  system clock, rising edge
//   Reset     asynchronous reset, active high
//   bus       can_form_checker_p_if.slave (strobe, bit, field code in; results out)
// Optional feature: define FORM_ERR_CNT_EN to build the saturating
// erroneous-frame counter on Err_count; otherwise Err_count is tied to 0.
module can_form_checker_p #(
  parameter int unsigned ESTADO_W        = 6,
  parameter int unsigned ST_IDA          = 0,
  parameter int unsigned ST_SRR          = 2,
  parameter int unsigned ST_CRCD         = 9,
  parameter int unsigned ST_ACKD         = 10,
  parameter int unsigned ST_EOF          = 20,
  parameter int unsigned EOF_LEN         = 7,
  parameter int unsigned LAST_EOF_IGNORE = 1,
  parameter int unsigned CNT_W           = 8
) (
  input logic                 Clock_TB,
  input logic                 Reset,
  can_form_checker_p_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StFrame, StDone} state_e;

  localparam logic [3:0] LastIdx = 4'(EOF_LEN - 1);

  state_e     state_q, state_d;
  logic [3:0] mon_q, mon_d;
  logic [3:0] pos_q, pos_d;
  logic [3:0] eof_cnt_q, eof_cnt_d;
  logic       srr_seen_q, srr_seen_d;
  logic       err_q, err_d;
  logic       done_q, done_d;
  logic       eof_bit_err;

  // A dominant final EOF bit is tolerated by receivers when LAST_EOF_IGNORE=1.
  assign eof_bit_err = !bus.Bit_Entrada &&
                       !((LAST_EOF_IGNORE != 0) && (eof_cnt_q == LastIdx));

  always_comb begin
    state_d    = state_q;
    mon_d      = mon_q;
    pos_d      = pos_q;
    eof_cnt_d  = eof_cnt_q;
    srr_seen_d = srr_seen_q;
    err_d      = 1'b0;
    done_d     = 1'b0;
    if (bus.Sample_Strobe) begin
      if (bus.Estado == ESTADO_W'(ST_IDA)) begin
        // Start of frame restarts from any state; no error pulse this cycle.
        state_d    = StFrame;
        mon_d      = 4'b0000;
        pos_d      = 4'd0;
        eof_cnt_d  = 4'd0;
        srr_seen_d = 1'b0;
      end else if (state_q == StFrame) begin
        if (bus.Estado == ESTADO_W'(ST_SRR)) begin
          // Only the first of the SRR/IDE pair is a fixed-form bit.
          if (!srr_seen_q) begin
            srr_seen_d = 1'b1;
            if (!bus.Bit_Entrada) mon_d[0] = 1'b1;
          end
        end else if (bus.Estado == ESTADO_W'(ST_CRCD)) begin
          if (!bus.Bit_Entrada) mon_d[1] = 1'b1;
        end else if (bus.Estado == ESTADO_W'(ST_ACKD)) begin
          if (!bus.Bit_Entrada) mon_d[2] = 1'b1;
        end else if (bus.Estado == ESTADO_W'(ST_EOF)) begin
          if (eof_bit_err) begin
            mon_d[3] = 1'b1;
            if (!mon_q[3]) pos_d = eof_cnt_q;
          end
          eof_cnt_d = eof_cnt_q + 4'd1;
          if (eof_cnt_q == LastIdx) begin
            done_d  = 1'b1;
            state_d = StDone;
          end
        end
        err_d = (mon_q == 4'b0000) && (mon_d != 4'b0000);
      end
    end
  end

  always_ff @(posedge Clock_TB or posedge Reset) begin
    if (Reset) begin
      state_q    <= StIdle;
      mon_q      <= 4'b0000;
      pos_q      <= 4'd0;
      eof_cnt_q  <= 4'd0;
      srr_seen_q <= 1'b0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mon_q      <= mon_d;
      pos_q      <= pos_d;
      eof_cnt_q  <= eof_cnt_d;
      srr_seen_q <= srr_seen_d;
      err_q      <= err_d;
      done_q     <= done_d;
    end
  end

  assign bus.Form_monitor = mon_q;
  assign bus.Form_error   = err_q;
  assign bus.Eof_err_pos  = pos_q;
  assign bus.Frame_done   = done_q;

`ifdef FORM_ERR_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Uses next-state flags so an error on the final EOF bit still counts.
  always_comb begin
    cnt_d = cnt_q;
    if (done_d && (mon_d != 4'b0000) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clock_TB or posedge Reset) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.Err_count = cnt_q;
`else
  assign bus.Err_count = '0;
`endif

endmodule
